cont_servo_test_top: RTL and testbench

CONT_SERVO_TEST_TOP -- requirements
Module: cont_servo_test_top

---
 rtl/cont_servo_pkg.sv | 22 ++
 rtl/servo_pwm.sv | 34 +++
 rtl/cont_servo_test_top.sv | 214 +++++++++++++++++++++
 tb/tb_cont_servo_test_top.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cont_servo_pkg.sv
// Shared defaults, UART state encodings and the speed-code to pulse-width mapping
// for the two-channel continuous-servo tester.
package cont_servo_pkg;

  localparam int CLK_HZ_DEF     = 10_000_000;
  localparam int BAUD_DEF       = 115_200;
  localparam int PWM_PERIOD_DEF = 200_000;
  localparam int CENTER_DEF     = 15_000;
  localparam int STEP_DEF       = 78;
  localparam int STOP_CODE      = 64;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Signed 32-bit math so codes below STOP_CODE step down from center; floor at 0.
  function automatic int code_to_width(input logic [6:0] code, input int center, input int step);
    int w;
    w = center + (int'({25'd0, code}) - STOP_CODE) * step;
    return (w < 0) ? 0 : w;
  endfunction

endpackage

// File: rtl/servo_pwm.sv
// One servo channel: pulse width register reloaded only at frame wrap,
// output high while the shared frame counter is below that width.
module servo_pwm
  import cont_servo_pkg::*;
#(
  parameter int               CNT_W       = 18,
  parameter logic [CNT_W-1:0] RESET_WIDTH = CNT_W'(CENTER_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             pwm_o
);

  logic [CNT_W-1:0] width_q;
  logic             pwm_q;

  // Output is registered, so it lags the counter by one clock; the width in use
  // only changes between frames, which keeps every pulse whole.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width_q <= RESET_WIDTH;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= (cnt_i < width_q);
      if (wrap_i) width_q <= width_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/cont_servo_test_top.sv
// UART-commanded two-channel servo tester: each received byte picks a servo and
// speed code, is applied at the next PWM frame, and is echoed back on TXD.
module cont_servo_test_top
  import cont_servo_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int CENTER     = CENTER_DEF,
  parameter int STEP       = STEP_DEF
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  input  logic UART_0_RXD,
  output logic UART_0_TXD,
  output logic M2F_GPO_0,
  output logic M2F_GPO_1,
  inout  wire  I2C_1_SCL,
  inout  wire  I2C_1_SDA
);

  localparam int               BIT_CLKS    = CLK_HZ / BAUD;
  localparam int               BW          = $clog2(BIT_CLKS);
  localparam logic [BW-1:0]    BIT_LAST    = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0]    HALF_LAST   = BW'(BIT_CLKS / 2 - 1);
  localparam int               CNT_W       = $clog2(PWM_PERIOD + 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] CENTER_W    = CNT_W'(CENTER);

  assign I2C_1_SCL = 1'bz;
  assign I2C_1_SDA = 1'bz;

  // ---------------- shared PWM frame counter ----------------
  logic [CNT_W-1:0] pwm_cnt_q;
  logic             pwm_wrap;

  assign pwm_wrap = (pwm_cnt_q == PERIOD_LAST);

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) pwm_cnt_q <= '0;
    else          pwm_cnt_q <= pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
  end

  // ---------------- UART receiver ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            rx_fall;
  rx_state_t       rx_state_q, rx_state_d;
  logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid;

  // Falling-edge start detection means a line held low never re-arms the receiver.
  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= UART_0_RXD;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_valid   = rx_sync_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- command decode and servo channels ----------------
  logic [CNT_W-1:0] new_width;
  logic [1:0]       pwm;

  assign new_width = CNT_W'(code_to_width(rx_shift_q[6:0], CENTER, STEP));

  for (genvar gi = 0; gi < 2; gi++) begin : g_servo
    logic [CNT_W-1:0] cmd_width_q;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET)                                 cmd_width_q <= CENTER_W;
      else if (rx_valid && rx_shift_q[7] == 1'(gi)) cmd_width_q <= new_width;
    end

    servo_pwm #(.CNT_W(CNT_W), .RESET_WIDTH(CENTER_W)) u_pwm (
      .clk_i  (SYSCLK),
      .rst_i  (SYSRESET),
      .cnt_i  (pwm_cnt_q),
      .wrap_i (pwm_wrap),
      .width_i(cmd_width_q),
      .pwm_o  (pwm[gi])
    );
  end

  assign M2F_GPO_0 = pwm[0];
  assign M2F_GPO_1 = pwm[1];

  // ---------------- echo buffer and UART transmitter ----------------
  logic          buf_full_q, buf_full_d;
  logic [7:0]    buf_data_q, buf_data_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;
  logic          tx_take;

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_take    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (buf_full_q) begin
          tx_take    = 1'b1;
          tx_shift_d = buf_data_q;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Every echo passes through the buffer; a byte arriving while it is occupied is dropped.
    buf_full_d = buf_full_q & ~tx_take;
    buf_data_d = buf_data_q;
    if (rx_valid && !buf_full_d) begin
      buf_full_d = 1'b1;
      buf_data_d = rx_shift_q;
    end

    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  assign UART_0_TXD = txd_q;

endmodule

// File: tb/tb_cont_servo_test_top.sv
// Directed bench: shortened PWM frame (2000 clocks, center 1000, step 10) keeps the
// run short; UART timing stays at 86 clocks per bit. TXD is decoded by a monitor.
`timescale 1ns/1ps
module tb_cont_servo_test_top;

  localparam int BITC = 86;
  localparam int LIM  = 4000;
  localparam int W0   = 360;   // 1000 + (0   - 64) * 10
  localparam int W64  = 1000;
  localparam int W127 = 1630;  // 1000 + (127 - 64) * 10

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd, gpo0, gpo1;
  wire  scl, sda;

  int total = 0;
  int bad   = 0;
  int tx_falls = 0;
  logic [8:0] echo_q[$];

  always #50 clk = ~clk;

  cont_servo_test_top #(
    .CLK_HZ(10_000_000), .BAUD(115_200), .PWM_PERIOD(2000), .CENTER(1000), .STEP(10)
  ) dut (
    .SYSCLK(clk), .SYSRESET(rst), .UART_0_RXD(rxd), .UART_0_TXD(txd),
    .M2F_GPO_0(gpo0), .M2F_GPO_1(gpo1), .I2C_1_SCL(scl), .I2C_1_SDA(sda)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic gpo(input int sel);
    return (sel != 0) ? gpo1 : gpo0;
  endfunction

  // Width of the next complete high pulse; -1 if any phase times out.
  task automatic measure(input int sel, output int w);
    int n;
    w = -1;
    n = 0;
    while (gpo(sel) !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    n = 0;
    while (gpo(sel) !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (gpo(sel) === 1'b1) begin
      w = 0;
      while (gpo(sel) === 1'b1 && w < LIM) begin @(negedge clk); w++; end
      if (w >= LIM) w = -1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = stop;
    repeat (BITC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_echo(input int n);
    int k;
    k = 0;
    while (echo_q.size() < n && k < LIM) begin @(negedge clk); k++; end
  endtask

  function automatic logic [31:0] pop_echo();
    if (echo_q.size() == 0) return '1;
    return {23'd0, echo_q.pop_front()};
  endfunction

  // TXD decoder: pushes {stop, data}; frames overlapping a reset are discarded.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic       stp;
    bit         ok;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev && !txd) begin
        tx_falls++;
        ok = 1'b1;
        for (int k = 0; k < BITC / 2; k++) begin @(negedge clk); if (rst) ok = 1'b0; end
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < BITC; k++) begin @(negedge clk); if (rst) ok = 1'b0; end
          b[i] = txd;
        end
        for (int k = 0; k < BITC; k++) begin @(negedge clk); if (rst) ok = 1'b0; end
        stp = txd;
        if (ok) echo_q.push_back({stp, b});
      end
      prev = txd;
    end
  end

  initial begin : stim
    int w, l, k, f0;

    // Reset state and idle behaviour
    rst = 1'b1; rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_gpo0", gpo0, 0);
    chk("rst_gpo1", gpo1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_edge_gpo0", gpo0, 1);
    chk("first_edge_gpo1", gpo1, 1);
    measure(0, w);
    chk("idle_w0", w, W64);
    l = 0;
    while (gpo0 === 1'b0 && l < LIM) begin @(negedge clk); l++; end
    chk("idle_period", w + l, 2000);
    measure(1, w);
    chk("idle_w1", w, W64);
    chk("idle_txd", txd, 1);
    chk("idle_no_echo", tx_falls, 0);

    // 0x00: servo 0 to code 0
    send_byte(8'h00, 1'b1);
    measure(0, w);  chk("cmd00_w0", w, W0);
    measure(1, w);  chk("cmd00_w1", w, W64);
    wait_echo(1);
    chk("cmd00_echo_cnt", echo_q.size(), 1);
    chk("cmd00_echo_val", pop_echo(), 9'h100);

    // 0xFF: servo 1 to code 127
    send_byte(8'hFF, 1'b1);
    measure(1, w);  chk("cmdFF_w1", w, W127);
    measure(0, w);  chk("cmdFF_w0", w, W0);
    wait_echo(1);
    chk("cmdFF_echo_cnt", echo_q.size(), 1);
    chk("cmdFF_echo_val", pop_echo(), 9'h1FF);

    // RXD held low from reset
    f0 = tx_falls;
    rst = 1'b1; rxd = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    measure(0, w);  chk("break_w0", w, W64);
    measure(1, w);  chk("break_w1", w, W64);
    chk("break_txd", txd, 1);
    chk("break_echo_cnt", echo_q.size(), 0);
    chk("break_tx_falls", tx_falls - f0, 0);
    rxd = 1'b1;
    repeat (300) @(negedge clk);

    // Framing error on 0x10, then valid 0x40
    send_byte(8'h10, 1'b0);
    repeat (300) @(negedge clk);
    measure(0, w);  chk("ferr_w0", w, W64);
    chk("ferr_echo_cnt", echo_q.size(), 0);
    send_byte(8'h40, 1'b1);
    wait_echo(1);
    chk("cmd40_echo_cnt", echo_q.size(), 1);
    chk("cmd40_echo_val", pop_echo(), 9'h140);
    measure(0, w);  chk("cmd40_w0", w, W64);

    // Back-to-back 0x01 then 0x7F: last one wins, both echoed in order
    send_byte(8'h01, 1'b1);
    send_byte(8'h7F, 1'b1);
    measure(0, w);  chk("b2b_w0", w, W127);
    wait_echo(2);
    chk("b2b_echo_cnt", echo_q.size(), 2);
    chk("b2b_echo_1", pop_echo(), 9'h101);
    chk("b2b_echo_2", pop_echo(), 9'h17F);

    // Reset in the middle of an all-zero echo
    send_byte(8'h00, 1'b1);
    k = 0;
    while (txd !== 1'b0 && k < 500) begin @(negedge clk); k++; end
    repeat (200) @(negedge clk);
    chk("mid_echo_low", txd, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_echo_txd", txd, 1);
    chk("rst_mid_echo_gpo0", gpo0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    f0 = tx_falls;
    repeat (1500) @(negedge clk);
    chk("post_rst_echo_cnt", echo_q.size(), 0);
    chk("post_rst_tx_falls", tx_falls - f0, 0);
    chk("post_rst_txd", txd, 1);
    measure(0, w);  chk("post_rst_w0", w, W64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
